// File: rtl/theme_fade_ctrl_pkg.sv
// Shared types, palette table and RGB565 helpers for the theme fade controller.
package theme_fade_ctrl_pkg;

  localparam int NUM_THEMES  = 3;
  localparam int NUM_COLOURS = 5;

  localparam int BACK   = 0;
  localparam int LOW    = 1;
  localparam int MED    = 2;
  localparam int HIGH   = 3;
  localparam int BORDER = 4;

  typedef logic [15:0] rgb565_t;
  typedef logic [1:0]  theme_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    FADE       = 2'd2
  } state_t;

  // Rows are themes, columns follow the BACK..BORDER index order.
  localparam rgb565_t PALETTE [NUM_THEMES][NUM_COLOURS] = '{
    '{16'h0000, 16'h07E0, 16'hFFE0, 16'hF800, 16'hFFFF},
    '{16'hDFE0, 16'hF80F, 16'hC81F, 16'h681F, 16'hFC00},
    '{16'h3D19, 16'h31A6, 16'h632C, 16'hAD55, 16'h0000}
  };

  function automatic rgb_t split_rgb(input rgb565_t c);
    return rgb_t'(c);
  endfunction

  function automatic rgb565_t pack_rgb(input rgb_t c);
    return rgb565_t'(c);
  endfunction

  function automatic theme_t next_theme(input theme_t t);
    return (t == theme_t'(NUM_THEMES - 1)) ? theme_t'(0) : t + theme_t'(1);
  endfunction

endpackage

// File: rtl/theme_fade_ctrl_if.sv
// Button, frame strobe and palette outputs shared between the controller and the display side.
interface theme_fade_ctrl_if;
  import theme_fade_ctrl_pkg::*;

  logic    btn_raw;
  logic    frame_begin;
  rgb565_t back_col;
  rgb565_t low_col;
  rgb565_t med_col;
  rgb565_t high_col;
  rgb565_t border_col;
  theme_t  theme_idx;
  logic    busy;

  modport master (
    output btn_raw, frame_begin,
    input  back_col, low_col, med_col, high_col, border_col, theme_idx, busy
  );

  modport slave (
    input  btn_raw, frame_begin,
    output back_col, low_col, med_col, high_col, border_col, theme_idx, busy
  );
endinterface

// File: rtl/theme_fade_ctrl_btn_debounce.sv
// Two-flop synchroniser plus stability counter; emits a one-cycle pulse on an accepted press.
module theme_fade_ctrl_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic req
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          settled;

  assign settled = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

  // NOTE: every register here uses <= so all flops sample the pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      req     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      req    <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (settled) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        req     <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/theme_fade_ctrl.sv
// Palette owner: steps through themes on a debounced press and cross-fades colours frame by frame.
module theme_fade_ctrl
  import theme_fade_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int FADE_SHIFT      = 4
) (
  input logic              clk,
  input logic              rst,
  theme_fade_ctrl_if.slave bus
);

  localparam int KW = FADE_SHIFT + 1;
  localparam int AW = 6 + KW;
  localparam logic [KW-1:0] N = KW'(1) << FADE_SHIFT;

  state_t        state_q, state_d;
  theme_t        theme_q, theme_d;
  theme_t        src_q, src_d;
  logic [KW-1:0] k_q, k_d, k_next;
  logic          pending_q, pending_d;
  logic          req;
  rgb565_t       col_q   [NUM_COLOURS];
  rgb565_t       col_d   [NUM_COLOURS];
  rgb565_t       blend_c [NUM_COLOURS];

  theme_fade_ctrl_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_raw),
    .req     (req)
  );

  // Channels are widened to 6 bits so R, G and B share one expression.
  function automatic logic [5:0] mix_ch(input logic [5:0] s, input logic [5:0] d,
                                        input logic [KW-1:0] kk);
    logic [AW-1:0] acc;
    acc = AW'(s) * AW'(N - kk) + AW'(d) * AW'(kk);
    return acc[FADE_SHIFT +: 6];
  endfunction

  function automatic rgb565_t mix_rgb(input rgb565_t s, input rgb565_t d,
                                      input logic [KW-1:0] kk);
    rgb_t a, b, o;
    a   = split_rgb(s);
    b   = split_rgb(d);
    o.r = 5'(mix_ch({1'b0, a.r}, {1'b0, b.r}, kk));
    o.g = mix_ch(a.g, b.g, kk);
    o.b = 5'(mix_ch({1'b0, a.b}, {1'b0, b.b}, kk));
    return pack_rgb(o);
  endfunction

  always_comb begin
    k_next = (state_q == WAIT_FRAME) ? KW'(1) : k_q + KW'(1);
    for (int i = 0; i < NUM_COLOURS; i++) begin
      blend_c[i] = mix_rgb(PALETTE[src_q][i], PALETTE[theme_q][i], k_next);
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    theme_d   = theme_q;
    src_d     = src_q;
    k_d       = k_q;
    pending_d = pending_q;
    col_d     = col_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          src_d   = theme_q;
          theme_d = next_theme(theme_q);
          k_d     = '0;
          state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME, FADE: begin
        if (req) pending_d = 1'b1;
        if (bus.frame_begin) begin
          k_d     = k_next;
          col_d   = blend_c;
          state_d = FADE;
          // A request landing on the final frame chains straight into the next fade.
          if (k_next == N) begin
            if (pending_d) begin
              pending_d = 1'b0;
              src_d     = theme_q;
              theme_d   = next_theme(theme_q);
              k_d       = '0;
              state_d   = WAIT_FRAME;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the colour array is ordinary flops, so it resets straight to the theme-0 palette.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      theme_q   <= '0;
      src_q     <= '0;
      k_q       <= '0;
      pending_q <= 1'b0;
      for (int i = 0; i < NUM_COLOURS; i++) col_q[i] <= PALETTE[0][i];
    end else begin
      state_q   <= state_d;
      theme_q   <= theme_d;
      src_q     <= src_d;
      k_q       <= k_d;
      pending_q <= pending_d;
      col_q     <= col_d;
    end
  end

  assign bus.back_col   = col_q[BACK];
  assign bus.low_col    = col_q[LOW];
  assign bus.med_col    = col_q[MED];
  assign bus.high_col   = col_q[HIGH];
  assign bus.border_col = col_q[BORDER];
  assign bus.theme_idx  = theme_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_theme_fade_ctrl.sv
// Self-checking bench: directed scenarios plus random button/frame traffic against a behavioural model.
module tb_theme_fade_ctrl;

  localparam int DC = 4;
  localparam int FS = 4;
  localparam int NF = 1 << FS;

  typedef logic [15:0] c16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  theme_fade_ctrl_if bus ();

  theme_fade_ctrl #(.DEBOUNCE_CYCLES(DC), .FADE_SHIFT(FS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Palette copied from the colour table of the design description.
  c16 pal [3][5] = '{
    '{16'h0000, 16'h07E0, 16'hFFE0, 16'hF800, 16'hFFFF},
    '{16'hDFE0, 16'hF80F, 16'hC81F, 16'h681F, 16'hFC00},
    '{16'h3D19, 16'h31A6, 16'h632C, 16'hAD55, 16'h0000}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_theme = 0, m_src = 0, m_k = 0, m_busy = 0, m_pending = 0;
  int m_lvl = 0, m_req = 0;
  c16 m_col [5];
  bit hist [$];
  bit s_fb, s_btn, s_accept;

  function automatic c16 blend_ref(input c16 s, input c16 d, input int k);
    int r, g, b;
    r = (int'(s[15:11]) * (NF - k) + int'(d[15:11]) * k) / NF;
    g = (int'(s[10:5])  * (NF - k) + int'(d[10:5])  * k) / NF;
    b = (int'(s[4:0])   * (NF - k) + int'(d[4:0])   * k) / NF;
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  task automatic model_reset();
    m_theme = 0; m_src = 0; m_k = 0; m_busy = 0; m_pending = 0;
    m_lvl = 0; m_req = 0;
    for (int c = 0; c < 5; c++) m_col[c] = pal[0][c];
    hist = {};
    for (int i = 0; i < DC + 2; i++) hist.push_back(1'b0);
  endtask

  task automatic model_start();
    m_src   = m_theme;
    m_theme = (m_theme + 1) % 3;
    m_k     = 0;
    m_busy  = 1;
  endtask

  initial model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      s_fb  = bus.frame_begin;
      s_btn = bus.btn_raw;
      if (m_busy == 0) begin
        if (m_req != 0) model_start();
      end else begin
        if (m_req != 0) m_pending = 1;
        if (s_fb) begin
          m_k++;
          for (int c = 0; c < 5; c++) m_col[c] = blend_ref(pal[m_src][c], pal[m_theme][c], m_k);
          if (m_k == NF) begin
            if (m_pending != 0) begin
              m_pending = 0;
              model_start();
            end else begin
              m_busy = 0;
            end
          end
        end
      end
      // Level is accepted once the last DC synchronised samples (two clocks old) all disagree with it.
      hist.push_front(s_btn);
      void'(hist.pop_back());
      s_accept = 1'b1;
      for (int i = 2; i < DC + 2; i++) if (hist[i] == m_lvl[0]) s_accept = 1'b0;
      m_req = 0;
      if (s_accept) begin
        m_lvl = 1 - m_lvl;
        m_req = m_lvl;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  bit fb_seen = 1'b0;
  c16 snap [5];

  always @(posedge clk) if (bus.frame_begin) fb_seen <= 1'b1;

  always @(negedge clk) begin
    c16 cur [5];
    bit changed;
    cur = '{bus.back_col, bus.low_col, bus.med_col, bus.high_col, bus.border_col};
    check("back_col",   32'(bus.back_col),   32'(m_col[0]));
    check("low_col",    32'(bus.low_col),    32'(m_col[1]));
    check("med_col",    32'(bus.med_col),    32'(m_col[2]));
    check("high_col",   32'(bus.high_col),   32'(m_col[3]));
    check("border_col", 32'(bus.border_col), 32'(m_col[4]));
    check("theme_idx",  32'(bus.theme_idx),  32'(m_theme));
    check("busy",       32'(bus.busy),       32'(m_busy));
    if (!rst && !fb_seen) begin
      changed = 1'b0;
      for (int c = 0; c < 5; c++) if (cur[c] !== snap[c]) changed = 1'b1;
      check("no_tear", 32'(changed), 32'(0));
    end
    snap    = cur;
    fb_seen <= 1'b0;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    bus.btn_raw = 1'b1;
    idle(10);
    bus.btn_raw = 1'b0;
    idle(10);
  endtask

  task automatic pulse_frame();
    bus.frame_begin = 1'b1;
    @(posedge clk);
    #1 bus.frame_begin = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_palette(input string tag, input int t);
    check({tag, "_back"},   32'(bus.back_col),   32'(pal[t][0]));
    check({tag, "_low"},    32'(bus.low_col),    32'(pal[t][1]));
    check({tag, "_med"},    32'(bus.med_col),    32'(pal[t][2]));
    check({tag, "_high"},   32'(bus.high_col),   32'(pal[t][3]));
    check({tag, "_border"}, 32'(bus.border_col), 32'(pal[t][4]));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit btn_state;
    bus.btn_raw     = 1'b0;
    bus.frame_begin = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_back",   32'(bus.back_col),   32'h0000);
    check("rst_low",    32'(bus.low_col),    32'h07E0);
    check("rst_med",    32'(bus.med_col),    32'hFFE0);
    check("rst_high",   32'(bus.high_col),   32'hF800);
    check("rst_border", 32'(bus.border_col), 32'hFFFF);
    check("rst_theme",  32'(bus.theme_idx),  32'd0);
    check("rst_busy",   32'(bus.busy),       32'd0);

    // Three-sample glitch must be rejected.
    bus.btn_raw = 1'b1;
    idle(3);
    bus.btn_raw = 1'b0;
    idle(20);
    check("glitch_theme", 32'(bus.theme_idx), 32'd0);
    check("glitch_busy",  32'(bus.busy),      32'd0);

    press();
    check("press_theme", 32'(bus.theme_idx), 32'd1);
    check("press_busy",  32'(bus.busy),      32'd1);

    // Fade 0 -> 1 with widely spaced frames.
    for (int f = 1; f <= NF; f++) begin
      pulse_frame();
      if (f == 8)  check("mid_back", 32'(bus.back_col), 32'h6BE0);
      if (f == NF) begin
        check("end_back", 32'(bus.back_col), 32'hDFE0);
        check("end_low",  32'(bus.low_col),  32'hF80F);
        check("end_busy", 32'(bus.busy),     32'd0);
      end
      idle(50);
    end

    // Pending: restart from theme 0, three presses, third dropped.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    press();
    pulse_frame(); idle(3);
    pulse_frame(); idle(3);
    press();
    press();
    for (int f = 3; f <= NF; f++) begin
      pulse_frame(); idle(3);
    end
    check("pend_theme", 32'(bus.theme_idx), 32'd2);
    check("pend_busy",  32'(bus.busy),      32'd1);
    for (int f = 1; f <= NF; f++) begin
      pulse_frame(); idle(3);
    end
    check_palette("pend_final", 2);
    idle(30);
    check("pend_idle", 32'(bus.busy), 32'd0);

    // Wrap 2 -> 0, queue another press, then reset asynchronously at frame 5.
    press();
    check("wrap_theme", 32'(bus.theme_idx), 32'd0);
    pulse_frame(); idle(2);
    press();
    for (int f = 2; f <= 4; f++) begin
      pulse_frame(); idle(2);
    end
    bus.frame_begin = 1'b1;
    @(posedge clk);
    #1 bus.frame_begin = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_palette("async_rst", 0);
    check("async_theme", 32'(bus.theme_idx), 32'd0);
    check("async_busy",  32'(bus.busy),      32'd0);
    idle(2);
    rst = 1'b0;

    // One press must yield a single fade, proving no stale pending request.
    press();
    for (int f = 1; f <= NF; f++) begin
      pulse_frame(); idle(1);
    end
    idle(10);
    check("post_rst_theme", 32'(bus.theme_idx), 32'd1);
    check("post_rst_busy",  32'(bus.busy),      32'd0);

    // Random traffic: sticky button with bounces, sporadic frame pulses.
    btn_state = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_state = ~btn_state;
      bus.btn_raw     = btn_state;
      bus.frame_begin = ($urandom_range(0, 5) == 0);
      idle(1);
    end
    bus.btn_raw     = 1'b0;
    bus.frame_begin = 1'b0;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
